// File: rtl/int_alu_arbiter.sv
// Two-port round-robin front end for a shared combinational integer ALU.
// Each port has a single-entry response buffer that holds the result until it is drained.
module int_alu_arbiter #(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,

   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_op,
   input  logic [31:0]      req0_a,
   input  logic [31:0]      req0_b,
   input  logic [TAG_W-1:0] req0_tag,

   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_op,
   input  logic [31:0]      req1_a,
   input  logic [31:0]      req1_b,
   input  logic [TAG_W-1:0] req1_tag,

   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [31:0]      rsp0_y,
   output logic [TAG_W-1:0] rsp0_tag,

   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [31:0]      rsp1_y,
   output logic [TAG_W-1:0] rsp1_tag,

   output logic [3:0]       alu_op,
   output logic [31:0]      alu_a,
   output logic [31:0]      alu_b,
   input  logic [31:0]      alu_y
);

   logic last_grant;
   logic elig0, elig1;
   logic grant0, grant1;

   always_comb begin
      elig0  = req0_valid && (!rsp0_valid || rsp0_ready);
      elig1  = req1_valid && (!rsp1_valid || rsp1_ready);
      // On contention the port that did not win last time goes first.
      grant0 = rst_n && elig0 && (!elig1 || last_grant);
      grant1 = rst_n && elig1 && (!elig0 || !last_grant);
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   always_comb begin
      alu_op = 4'd0;
      alu_a  = 32'd0;
      alu_b  = 32'd0;
      if (grant0) begin
         alu_op = req0_op;
         alu_a  = req0_a;
         alu_b  = req0_b;
      end else if (grant1) begin
         alu_op = req1_op;
         alu_a  = req1_a;
         alu_b  = req1_b;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
      end else if (grant0) begin
         last_grant <= 1'b0;
      end else if (grant1) begin
         last_grant <= 1'b1;
      end
   end

   // A grant on the same edge as a drain reloads the buffer, so valid stays high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp0_valid <= 1'b0;
         rsp0_y     <= 32'd0;
         rsp0_tag   <= '0;
      end else if (grant0) begin
         rsp0_valid <= 1'b1;
         rsp0_y     <= alu_y;
         rsp0_tag   <= req0_tag;
      end else if (rsp0_valid && rsp0_ready) begin
         rsp0_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp1_valid <= 1'b0;
         rsp1_y     <= 32'd0;
         rsp1_tag   <= '0;
      end else if (grant1) begin
         rsp1_valid <= 1'b1;
         rsp1_y     <= alu_y;
         rsp1_tag   <= req1_tag;
      end else if (rsp1_valid && rsp1_ready) begin
         rsp1_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_int_alu_arbiter.sv
// Bench for int_alu_arbiter: directed scenarios, a transaction-level model checked
// every cycle, and literal expectations at the key points of each scenario.
module tb_int_alu_arbiter;

   localparam int TW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req0_valid, req1_valid;
   logic          req0_ready, req1_ready;
   logic [3:0]    req0_op, req1_op;
   logic [31:0]   req0_a, req0_b, req1_a, req1_b;
   logic [TW-1:0] req0_tag, req1_tag;
   logic          rsp0_valid, rsp1_valid;
   logic          rsp0_ready, rsp1_ready;
   logic [31:0]   rsp0_y, rsp1_y;
   logic [TW-1:0] rsp0_tag, rsp1_tag;
   logic [3:0]    alu_op;
   logic [31:0]   alu_a, alu_b, alu_y;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   int_alu_arbiter #(.TAG_W(TW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_y(rsp0_y), .rsp0_tag(rsp0_tag),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_y(rsp1_y), .rsp1_tag(rsp1_tag),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y)
   );

   // Shared ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
   function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         default: return 32'd0;
      endcase
   endfunction

   assign alu_y = alu_fn(alu_op, alu_a, alu_b);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: per-port buffer contents and the identity of the last port served.
   logic          m_full0, m_full1, m_last;
   logic [31:0]   m_y0, m_y1;
   logic [TW-1:0] m_t0, m_t1;

   always @(negedge clk) begin
      logic ok0, ok1, win0, win1;
      logic [3:0]  e_op;
      logic [31:0] e_a, e_b;
      if (!rst_n) begin
         m_full0 = 1'b0; m_full1 = 1'b0; m_last = 1'b1;
         m_y0 = 32'd0; m_y1 = 32'd0; m_t0 = '0; m_t1 = '0;
         chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
         chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
         chk("rst_rsp0_y", rsp0_y, 32'd0);
         chk("rst_rsp1_y", rsp1_y, 32'd0);
         chk("rst_rsp0_tag", 32'(rsp0_tag), 32'd0);
         chk("rst_rsp1_tag", 32'(rsp1_tag), 32'd0);
         chk("rst_req0_ready", 32'(req0_ready), 32'd0);
         chk("rst_req1_ready", 32'(req1_ready), 32'd0);
      end else begin
         // A port may accept if its buffer is free now or frees up this cycle.
         ok0  = req0_valid && (!m_full0 || rsp0_ready);
         ok1  = req1_valid && (!m_full1 || rsp1_ready);
         win0 = ok0 && !(ok1 && m_last == 1'b0);
         win1 = ok1 && !win0;
         e_op = win0 ? req0_op : win1 ? req1_op : 4'd0;
         e_a  = win0 ? req0_a  : win1 ? req1_a  : 32'd0;
         e_b  = win0 ? req0_b  : win1 ? req1_b  : 32'd0;
         chk("req0_ready", 32'(req0_ready), 32'(win0));
         chk("req1_ready", 32'(req1_ready), 32'(win1));
         chk("alu_op", 32'(alu_op), 32'(e_op));
         chk("alu_a", alu_a, e_a);
         chk("alu_b", alu_b, e_b);
         chk("rsp0_valid", 32'(rsp0_valid), 32'(m_full0));
         chk("rsp1_valid", 32'(rsp1_valid), 32'(m_full1));
         if (m_full0) begin
            chk("rsp0_y", rsp0_y, m_y0);
            chk("rsp0_tag", 32'(rsp0_tag), 32'(m_t0));
         end
         if (m_full1) begin
            chk("rsp1_y", rsp1_y, m_y1);
            chk("rsp1_tag", 32'(rsp1_tag), 32'(m_t1));
         end
         if (m_full0 && rsp0_ready) m_full0 = 1'b0;
         if (m_full1 && rsp1_ready) m_full1 = 1'b0;
         if (win0) begin
            m_full0 = 1'b1; m_y0 = alu_fn(req0_op, req0_a, req0_b); m_t0 = req0_tag; m_last = 1'b0;
         end
         if (win1) begin
            m_full1 = 1'b1; m_y1 = alu_fn(req1_op, req1_a, req1_b); m_t1 = req1_tag; m_last = 1'b1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int g0, g1, r0, r1;
      rst_n = 1'b0;
      req0_valid = 1'b0; req0_op = 4'd0; req0_a = 32'd0; req0_b = 32'd0; req0_tag = '0;
      req1_valid = 1'b0; req1_op = 4'd0; req1_a = 32'd0; req1_b = 32'd0; req1_tag = '0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      step();
      req0_valid = 1'b1; req1_valid = 1'b1;
      sample();
      chk("lit_rst_no_ready", 32'({req0_ready, req1_ready}), 32'd0);
      chk("lit_rst_alu_zero", alu_a, 32'd0);

      // Reset release into contention: port 0 first, then port 1.
      step();
      req0_op = 4'd0; req0_a = 32'd5; req0_b = 32'd7; req0_tag = 4'd3;
      req1_op = 4'd0; req1_a = 32'd1; req1_b = 32'd1; req1_tag = 4'd9;
      rst_n = 1'b1;
      sample();
      chk("lit_first_grant0", 32'({req0_ready, req1_ready}), 32'b10);
      chk("lit_first_alu_a", alu_a, 32'd5);
      step();
      req0_valid = 1'b0;
      sample();
      chk("lit_second_grant1", 32'({req0_ready, req1_ready}), 32'b01);
      chk("lit_rsp0_y12", rsp0_y, 32'd12);
      chk("lit_rsp0_tag3", 32'(rsp0_tag), 32'd3);
      step();
      req1_valid = 1'b0;
      sample();
      chk("lit_rsp1_y2", rsp1_y, 32'd2);
      chk("lit_rsp1_tag9", 32'(rsp1_tag), 32'd9);
      chk("lit_rsp0_drained", 32'(rsp0_valid), 32'd0);

      // Back-pressure on port 0 blocks only port 0.
      step();
      rsp0_ready = 1'b0;
      req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd10; req0_b = 32'd20; req0_tag = 4'd1;
      step();
      req0_a = 32'd100;
      req1_valid = 1'b1; req1_op = 4'd1; req1_a = 32'd3; req1_b = 32'd5; req1_tag = 4'd5;
      for (int i = 0; i < 4; i++) begin
         sample();
         chk("lit_bp_req0_blocked", 32'(req0_ready), 32'd0);
         chk("lit_bp_req1_granted", 32'(req1_ready), 32'd1);
         step();
      end
      sample();
      chk("lit_bp_rsp1_y", rsp1_y, 32'hFFFF_FFFE);
      chk("lit_bp_rsp0_hold", rsp0_y, 32'd30);
      chk("lit_bp_rsp0_full", 32'(rsp0_valid), 32'd1);

      // Drain and refill port 0 on the same edge.
      step();
      req1_valid = 1'b0;
      rsp0_ready = 1'b1;
      req0_a = 32'd100; req0_b = 32'd1; req0_tag = 4'd2;
      sample();
      chk("lit_refill_grant", 32'(req0_ready), 32'd1);
      step();
      req0_a = 32'd7; req0_b = 32'd8; req0_tag = 4'd6;
      sample();
      chk("lit_refill_valid", 32'(rsp0_valid), 32'd1);
      chk("lit_refill_y101", rsp0_y, 32'd101);
      step();
      req0_valid = 1'b0;
      sample();
      chk("lit_refill_valid2", 32'(rsp0_valid), 32'd1);
      chk("lit_refill_y15", rsp0_y, 32'd15);
      step();
      step();

      // Sustained contention: last grant was port 0, so port 1 leads.
      g0 = 0; g1 = 0; r0 = 0; r1 = 0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         req0_op = 4'(i % 5); req0_a = 32'(i + 40); req0_b = 32'(i * 3);  req0_tag = 4'(i);
         req1_op = 4'((i + 2) % 5); req1_a = 32'(i * 7); req1_b = 32'(100 - i); req1_tag = 4'(15 - i);
         sample();
         chk("lit_rr_alt", 32'(req0_ready), 32'(i % 2));
         g0 += int'(req0_ready); g1 += int'(req1_ready);
         r0 += int'(rsp0_valid); r1 += int'(rsp1_valid);
         step();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      sample();
      r0 += int'(rsp0_valid); r1 += int'(rsp1_valid);
      chk("lit_rr_grants0", 32'(g0), 32'd4);
      chk("lit_rr_grants1", 32'(g1), 32'd4);
      chk("lit_rr_rsp0", 32'(r0), 32'd4);
      chk("lit_rr_rsp1", 32'(r1), 32'd4);

      // Idle keeps the ALU quiet and leaves the round-robin pointer alone.
      for (int i = 0; i < 3; i++) begin
         step();
         sample();
         chk("lit_idle_alu", alu_a | alu_b | 32'(alu_op), 32'd0);
         chk("lit_idle_ready", 32'({req0_ready, req1_ready}), 32'd0);
      end
      step();
      req0_valid = 1'b1; req1_valid = 1'b1;
      sample();
      chk("lit_idle_ptr_kept", 32'({req0_ready, req1_ready}), 32'b01);
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      step();

      // Reset mid-operation discards a full buffer and restores port-0 priority.
      rsp1_ready = 1'b0;
      req1_valid = 1'b1; req1_op = 4'd2; req1_a = 32'hF0F0_F0F0; req1_b = 32'hFF00_FF00;
      step();
      req1_valid = 1'b0; req0_valid = 1'b1;
      step();
      req0_valid = 1'b0;
      sample();
      chk("lit_prerst_rsp1_full", 32'(rsp1_valid), 32'd1);
      chk("lit_prerst_rsp1_y", rsp1_y, 32'hF000_F000);
      step();
      rst_n = 1'b0;
      #1;
      chk("lit_rst_async_rsp1", 32'(rsp1_valid), 32'd0);
      chk("lit_rst_async_y1", rsp1_y, 32'd0);
      step();
      rst_n = 1'b1; rsp1_ready = 1'b1;
      sample();
      chk("lit_postrst_no_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
      step();
      req0_valid = 1'b1; req1_valid = 1'b1;
      sample();
      chk("lit_postrst_port0_wins", 32'({req0_ready, req1_ready}), 32'b10);
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      step();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/int_alu_arbiter.md
INT_ALU_ARBITER -- requirements
Module: int_alu_arbiter

Interface
REQ-001 The module SHALL have parameter TAG_W, default 4, giving the width of the requester tag carried with each operation.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1, reset; reset is asynchronous and active-low.
REQ-004 The module SHALL have ports reqN_valid (input, 1) and reqN_ready (output, 1) for N in {0,1}: the request handshake.
REQ-005 The module SHALL have ports reqN_op (input, 4), reqN_a (input, 32), reqN_b (input, 32) and reqN_tag (input, TAG_W): the operation, operands and tag for requester N.
REQ-006 The module SHALL have ports rspN_valid (output, 1) and rspN_ready (input, 1): the response handshake for requester N.
REQ-007 The module SHALL have ports rspN_y (output, 32) and rspN_tag (output, TAG_W): the result and echoed tag for requester N.
REQ-008 The module SHALL have ports alu_op (output, 4), alu_a (output, 32) and alu_b (output, 32), driving the shared combinational integer ALU.
REQ-009 The module SHALL have port alu_y, input, 32: the ALU result, combinational in alu_op, alu_a and alu_b.

Function
REQ-010 Port N SHALL be eligible in a cycle when reqN_valid=1 and its response buffer is empty or being drained in that cycle (rspN_valid=1 and rspN_ready=1).
REQ-011 At most one request SHALL be granted per cycle; reqN_ready SHALL be 1 only for the granted port and SHALL be combinational in the current valids, buffer state and pointer.
REQ-012 If exactly one port is eligible, that port SHALL be granted.
REQ-013 If both ports are eligible, the port other than last_grant SHALL be granted (round-robin).
REQ-014 last_grant SHALL update to the granted port on every grant and SHALL hold when there is no grant.
REQ-015 When port N is granted, alu_op, alu_a and alu_b SHALL equal reqN_op, reqN_a and reqN_b in the same cycle.
REQ-016 When no port is granted, alu_op, alu_a and alu_b SHALL all be driven to 0.
REQ-017 On the grant edge, alu_y and reqN_tag SHALL be captured into response buffer N, and rspN_valid SHALL be 1 from the next cycle (latency 1 cycle, request accept to response valid).
REQ-018 A response buffer SHALL hold rspN_y, rspN_tag and rspN_valid stable until rspN_ready=1.
REQ-019 rspN_valid SHALL clear on the edge where rspN_valid=1 and rspN_ready=1, unless a new grant to port N loads the buffer on the same edge, in which case it SHALL stay 1 with the new data.
REQ-020 Throughput SHALL be one operation per cycle in aggregate; a single port with rspN_ready held at 1 SHALL sustain one operation per cycle.
REQ-021 A full response buffer with rspN_ready=0 SHALL block only port N; the other port SHALL still be grantable.
REQ-022 The ALU result width SHALL pass through unmodified (32 bits, no extension or truncation); tags SHALL be echoed bit-exact.
REQ-023 Responses on a port SHALL be returned in acceptance order (guaranteed by the single-entry buffer).

Reset
REQ-024 While rst_n=0, all of the following SHALL hold: rsp0_valid=rsp1_valid=0, rspN_y=0, rspN_tag=0, and last_grant=1 so that port 0 wins the first contention.
REQ-025 Reset asserted mid-operation SHALL discard buffered results; no response SHALL appear after reset is released without a new grant.
REQ-026 reqN_ready SHALL be 0 while rst_n=0.

Verification
REQ-027 Reset release with both valid, op=ADD: req0 a=5,b=7; req1 a=1,b=1 -> cycle 0 grants port 0 (alu_a=5); cycle 1 grants port 1; rsp0_y=12 then rsp1_y=2, tags echoed.
REQ-028 Back-pressure: rsp0_ready=0 with rsp0 full and req0 valid, req1 valid with SUB a=3,b=5 -> port 1 granted every cycle, rsp1_y=32'hFFFFFFFE, req0_ready=0.
REQ-029 Drain-and-refill: rsp0 full, rsp0_ready=1, req0 valid, port 1 idle -> same-edge drain and load, rsp0_valid stays 1, new data appears, no bubble.
REQ-030 Sustained contention: both ports valid for 8 cycles with ready=1 -> grants alternate 0,1,0,1..., 4 responses per port.
REQ-031 Idle: no valids -> alu_op=alu_a=alu_b=0, no ready asserted, last_grant unchanged.
REQ-032 Reset mid-operation: rst_n low for 1 cycle while rsp1_valid=1 -> rsp1_valid=0 immediately, and after release port 0 wins the first contention.
